// File: rtl/insight_tl_prot_responder.sv
// TileLink-UL manager for the Insight trace/debug register window.
// It checks the A-channel amba_prot bits against an access policy, reads or
// writes a small local register file, and returns D-channel acks through a
// 2-entry response FIFO.
module insight_tl_prot_responder #(
  parameter int                 ADDR_W    = 32,
  parameter int                 SOURCE_W  = 4,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int                 NREGS     = 8,
  parameter int                 PRIV_IDX  = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [1:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  input  logic                a_prot_privileged,
  input  logic                a_prot_secure,
  input  logic                a_prot_fetch,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic [31:0]         d_data,
  output logic [15:0]         deny_count
);

  localparam int         IDX_W      = $clog2(NREGS);
  localparam logic [2:0] OP_PUTFULL = 3'd0;
  localparam logic [2:0] OP_PUTPART = 3'd1;
  localparam logic [2:0] OP_GET     = 3'd4;
  localparam logic [2:0] OP_ACK     = 3'd0;
  localparam logic [2:0] OP_ACKDATA = 3'd1;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [1:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic                corrupt;
    logic [31:0]         data;
  } rsp_t;

  logic [NREGS-1:0][31:0] r_regs;
  rsp_t                   r_q [2];
  logic                   r_wptr;
  logic                   r_rptr;
  logic [1:0]             r_cnt;
  logic [15:0]            r_deny_count;

  logic [ADDR_W-1:0] w_offset;
  logic [IDX_W-1:0]  w_idx;
  logic              w_is_get;
  logic              w_is_put;
  logic              w_oob;
  logic              w_priv_region;
  logic              w_deny;
  logic              w_push;
  logic              w_pop;
  rsp_t              w_rsp;
  rsp_t              w_head;

  // Address decode: byte offset into the window, word index from bits above the low two.
  assign w_offset      = a_address - BASE_ADDR;
  assign w_idx         = w_offset[IDX_W+1:2];
  assign w_oob         = (w_offset >= ADDR_W'(4*NREGS));
  assign w_priv_region = (32'(w_idx) >= 32'(PRIV_IDX));
  assign w_is_get      = (a_opcode == OP_GET);
  assign w_is_put      = (a_opcode == OP_PUTFULL) || (a_opcode == OP_PUTPART);

  // Any single policy violation refuses the access.
  assign w_deny = w_oob
               || (a_size == 2'd3)
               || !(w_is_get || w_is_put)
               || a_prot_fetch
               || (w_priv_region && !a_prot_privileged)
               || (!a_prot_secure && w_is_put);

  // Full queue blocks A; the pop of the same cycle is deliberately not looked at.
  assign a_ready = (r_cnt != 2'd2);
  assign d_valid = (r_cnt != 2'd0);
  assign w_push  = a_valid && a_ready;
  assign w_pop   = d_valid && d_ready;
  assign w_head  = r_q[r_rptr];

  // Build the response at fire time so Get data reflects the register at acceptance.
  always_comb begin
    w_rsp         = '0;
    w_rsp.opcode  = w_is_get ? OP_ACKDATA : OP_ACK;
    w_rsp.size    = a_size;
    w_rsp.source  = a_source;
    w_rsp.denied  = w_deny;
    w_rsp.corrupt = w_deny && w_is_get;
    w_rsp.data    = (w_is_get && !w_deny) ? r_regs[w_idx] : 32'd0;
  end

  // Register file: byte-lane writes for granted Puts (PutFullData honours a_mask too).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_regs <= '0;
    end else if (w_push && w_is_put && !w_deny) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) r_regs[w_idx][b*8 +: 8] <= a_data[b*8 +: 8];
      end
    end
  end

  // Response FIFO: two slots, ring pointers plus an occupancy count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q[0] <= '0;
      r_q[1] <= '0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) begin
        r_q[r_wptr] <= w_rsp;
        r_wptr      <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Saturating count of refused requests.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_deny_count <= 16'd0;
    end else if (w_push && w_deny && (r_deny_count != 16'hFFFF)) begin
      r_deny_count <= r_deny_count + 16'd1;
    end
  end

  // D payload comes straight from the head slot; forced to zero while idle.
  always_comb begin
    d_opcode  = '0;
    d_size    = '0;
    d_source  = '0;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
    d_data    = '0;
    if (d_valid) begin
      d_opcode  = w_head.opcode;
      d_size    = w_head.size;
      d_source  = w_head.source;
      d_denied  = w_head.denied;
      d_corrupt = w_head.corrupt;
      d_data    = w_head.data;
    end
  end

  assign deny_count = r_deny_count;

endmodule

// File: tb/tb_insight_tl_prot_responder.sv
// Directed bench for insight_tl_prot_responder: policy, queueing, saturation, reset.
module tb_insight_tl_prot_responder;
  localparam int          AW   = 32;
  localparam int          SW   = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic          clock, reset_n;
  logic          a_valid, a_ready;
  logic [2:0]    a_opcode;
  logic [1:0]    a_size;
  logic [SW-1:0] a_source;
  logic [AW-1:0] a_address;
  logic [3:0]    a_mask;
  logic [31:0]   a_data;
  logic          a_prot_privileged, a_prot_secure, a_prot_fetch;
  logic          d_valid, d_ready;
  logic [2:0]    d_opcode;
  logic [1:0]    d_size;
  logic [SW-1:0] d_source;
  logic          d_denied, d_corrupt;
  logic [31:0]   d_data;
  logic [15:0]   deny_count;

  int n_cmp = 0;
  int n_bad = 0;

  insight_tl_prot_responder #(
    .ADDR_W(AW), .SOURCE_W(SW), .BASE_ADDR(BASE), .NREGS(8), .PRIV_IDX(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .a_prot_privileged(a_prot_privileged), .a_prot_secure(a_prot_secure),
    .a_prot_fetch(a_prot_fetch),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .d_data(d_data), .deny_count(deny_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step;
    @(posedge clock); #1;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [1:0] sz, input logic [SW-1:0] src,
                         input logic [31:0] addr, input logic [3:0] m, input logic [31:0] dat,
                         input logic pr, input logic sc, input logic fe);
    a_opcode = op; a_size = sz; a_source = src; a_address = addr; a_mask = m; a_data = dat;
    a_prot_privileged = pr; a_prot_secure = sc; a_prot_fetch = fe; a_valid = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; d_ready = 1'b1;
    drive_a(3'd4, 2'd2, '0, BASE, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    a_valid = 1'b0;
    #1;
    n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dvalid_in: got %b want 0", d_valid); end
    step; step;
    reset_n = 1'b1;
    step;
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL rst_aready: got %b want 1", a_ready); end
    n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dvalid: got %b want 0", d_valid); end
    n_cmp++; if (deny_count !== 16'd0) begin n_bad++; $display("FAIL rst_denycnt: got %h want 0", deny_count); end
    n_cmp++; if (d_data !== 32'd0) begin n_bad++; $display("FAIL rst_ddata: got %h want 0", d_data); end
  endtask

  task automatic test_put_get;
    drive_a(3'd0, 2'd2, 4'd1, BASE + 32'h8, 4'hF, 32'hA5A5_1234, 1'b1, 1'b1, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if (d_valid !== 1'b1) begin n_bad++; $display("FAIL put_dvalid: got %b want 1", d_valid); end
    n_cmp++; if ({d_opcode, d_denied, d_corrupt} !== {3'd0, 1'b0, 1'b0})
      begin n_bad++; $display("FAIL put_ack: got op=%0d den=%b cor=%b want op=0 den=0 cor=0", d_opcode, d_denied, d_corrupt); end
    n_cmp++; if (d_source !== 4'd1) begin n_bad++; $display("FAIL put_source: got %0d want 1", d_source); end
    drive_a(3'd4, 2'd2, 4'd2, BASE + 32'h8, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if (d_opcode !== 3'd1) begin n_bad++; $display("FAIL get_opcode: got %0d want 1", d_opcode); end
    n_cmp++; if (d_data !== 32'hA5A5_1234) begin n_bad++; $display("FAIL get_data: got %h want a5a51234", d_data); end
    n_cmp++; if (d_source !== 4'd2 || d_denied !== 1'b0)
      begin n_bad++; $display("FAIL get_src_den: got src=%0d den=%b want src=2 den=0", d_source, d_denied); end
    step;
  endtask

  task automatic test_partial;
    drive_a(3'd1, 2'd2, 4'd3, BASE + 32'h8, 4'b0010, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if (d_opcode !== 3'd0 || d_denied !== 1'b0)
      begin n_bad++; $display("FAIL ppart_ack: got op=%0d den=%b want op=0 den=0", d_opcode, d_denied); end
    drive_a(3'd4, 2'd2, 4'd4, BASE + 32'h8, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if (d_data !== 32'hA5A5_FF34) begin n_bad++; $display("FAIL ppart_data: got %h want a5a5ff34", d_data); end
    step;
  endtask

  task automatic test_deny;
    drive_a(3'd4, 2'd2, 4'd5, BASE + 32'h10, 4'hF, 32'd0, 1'b0, 1'b1, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if ({d_opcode, d_denied, d_corrupt} !== {3'd1, 1'b1, 1'b1} || d_data !== 32'd0)
      begin n_bad++; $display("FAIL priv_deny: got op=%0d den=%b cor=%b data=%h want 1 1 1 0", d_opcode, d_denied, d_corrupt, d_data); end
    n_cmp++; if (deny_count !== 16'd1) begin n_bad++; $display("FAIL priv_cnt: got %0d want 1", deny_count); end
    drive_a(3'd4, 2'd2, 4'd6, BASE + 32'h8, 4'hF, 32'd0, 1'b1, 1'b1, 1'b1);
    step; a_valid = 1'b0;
    n_cmp++; if (d_denied !== 1'b1 || d_data !== 32'd0)
      begin n_bad++; $display("FAIL fetch_deny: got den=%b data=%h want den=1 data=0", d_denied, d_data); end
    n_cmp++; if (deny_count !== 16'd2) begin n_bad++; $display("FAIL fetch_cnt: got %0d want 2", deny_count); end
    drive_a(3'd0, 2'd2, 4'd7, BASE, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if ({d_opcode, d_denied, d_corrupt} !== {3'd0, 1'b1, 1'b0})
      begin n_bad++; $display("FAIL nonsec_put: got op=%0d den=%b cor=%b want 0 1 0", d_opcode, d_denied, d_corrupt); end
    n_cmp++; if (deny_count !== 16'd3) begin n_bad++; $display("FAIL nonsec_cnt: got %0d want 3", deny_count); end
    drive_a(3'd4, 2'd2, 4'd8, BASE, 4'hF, 32'd0, 1'b0, 1'b0, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if (d_denied !== 1'b0 || d_data !== 32'd0)
      begin n_bad++; $display("FAIL nonsec_nowrite: got den=%b data=%h want den=0 data=0", d_denied, d_data); end
    drive_a(3'd4, 2'd2, 4'd9, BASE + 32'h10, 4'hF, 32'd0, 1'b1, 1'b0, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if (d_denied !== 1'b0 || deny_count !== 16'd3)
      begin n_bad++; $display("FAIL priv_grant: got den=%b cnt=%0d want den=0 cnt=3", d_denied, deny_count); end
    step;
  endtask

  task automatic test_back_to_back;
    n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b want 0", d_valid); end
    d_ready = 1'b0;
    drive_a(3'd4, 2'd2, 4'd1, BASE + 32'h8, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step;
    n_cmp++; if (a_ready !== 1'b1 || d_valid !== 1'b1 || d_source !== 4'd1)
      begin n_bad++; $display("FAIL b2b_first: got rdy=%b vld=%b src=%0d want 1 1 1", a_ready, d_valid, d_source); end
    a_source = 4'd2;
    step;
    n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full: got a_ready=%b want 0", a_ready); end
    a_source = 4'd3;
    step;
    n_cmp++; if (a_ready !== 1'b0 || d_valid !== 1'b1 || d_source !== 4'd1 || d_data !== 32'hA5A5_FF34)
      begin n_bad++; $display("FAIL b2b_stall: got rdy=%b vld=%b src=%0d data=%h want 0 1 1 a5a5ff34", a_ready, d_valid, d_source, d_data); end
    d_ready = 1'b1;
    step;
    n_cmp++; if (d_source !== 4'd2 || a_ready !== 1'b1)
      begin n_bad++; $display("FAIL b2b_second: got src=%0d rdy=%b want src=2 rdy=1", d_source, a_ready); end
    step; a_valid = 1'b0;
    n_cmp++; if (d_valid !== 1'b1 || d_source !== 4'd3 || d_data !== 32'hA5A5_FF34)
      begin n_bad++; $display("FAIL b2b_third: got vld=%b src=%0d data=%h want 1 3 a5a5ff34", d_valid, d_source, d_data); end
    step;
    n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", d_valid); end
  endtask

  task automatic test_boundary;
    drive_a(3'd4, 2'd2, 4'd1, BASE + 32'h20, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if ({d_opcode, d_denied, d_corrupt} !== {3'd1, 1'b1, 1'b1} || deny_count !== 16'd4)
      begin n_bad++; $display("FAIL oob_get: got op=%0d den=%b cor=%b cnt=%0d want 1 1 1 4", d_opcode, d_denied, d_corrupt, deny_count); end
    drive_a(3'd2, 2'd2, 4'd2, BASE + 32'h8, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if ({d_opcode, d_denied, d_corrupt} !== {3'd0, 1'b1, 1'b0} || deny_count !== 16'd5)
      begin n_bad++; $display("FAIL bad_opcode: got op=%0d den=%b cor=%b cnt=%0d want 0 1 0 5", d_opcode, d_denied, d_corrupt, deny_count); end
    drive_a(3'd4, 2'd3, 4'd3, BASE + 32'h8, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if (d_denied !== 1'b1 || d_size !== 2'd3 || d_data !== 32'd0 || deny_count !== 16'd6)
      begin n_bad++; $display("FAIL size3_get: got den=%b size=%0d data=%h cnt=%0d want 1 3 0 6", d_denied, d_size, d_data, deny_count); end
    drive_a(3'd0, 2'd2, 4'd4, BASE + 32'h28, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step;
    drive_a(3'd0, 2'd3, 4'd5, BASE + 32'h8, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step;
    drive_a(3'd4, 2'd2, 4'd6, BASE - 32'h4, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if (d_denied !== 1'b1 || deny_count !== 16'd9)
      begin n_bad++; $display("FAIL below_base: got den=%b cnt=%0d want 1 9", d_denied, deny_count); end
    drive_a(3'd4, 2'd2, 4'd7, BASE + 32'h8, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if (d_denied !== 1'b0 || d_data !== 32'hA5A5_FF34)
      begin n_bad++; $display("FAIL reg_unchanged: got den=%b data=%h want 0 a5a5ff34", d_denied, d_data); end
    drive_a(3'd4, 2'd2, 4'd8, BASE + 32'h1C, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if (d_denied !== 1'b0 || d_data !== 32'd0 || deny_count !== 16'd9)
      begin n_bad++; $display("FAIL last_reg: got den=%b data=%h cnt=%0d want 0 0 9", d_denied, d_data, deny_count); end
    step;
  endtask

  task automatic test_saturate;
    int need, fires;
    logic fired;
    need  = 65535 - 9 + 3;
    fires = 0;
    drive_a(3'd4, 2'd2, 4'd1, BASE, 4'hF, 32'd0, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < need + 100; n++) begin
      fired = a_ready;
      step;
      if (fired) fires++;
      if (fires == need) break;
    end
    a_valid = 1'b0;
    n_cmp++; if (fires != need) begin n_bad++; $display("FAIL sat_fires: got %0d want %0d", fires, need); end
    n_cmp++; if (deny_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_count: got %h want ffff", deny_count); end
    step;
  endtask

  task automatic test_reset_mid;
    d_ready = 1'b0;
    drive_a(3'd4, 2'd2, 4'd1, BASE + 32'h8, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step; a_source = 4'd2;
    step; a_valid = 1'b0;
    n_cmp++; if (d_valid !== 1'b1 || a_ready !== 1'b0)
      begin n_bad++; $display("FAIL mid_full: got vld=%b rdy=%b want 1 0", d_valid, a_ready); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (d_valid !== 1'b0 || deny_count !== 16'd0 || d_data !== 32'd0)
      begin n_bad++; $display("FAIL mid_async: got vld=%b cnt=%h data=%h want 0 0 0", d_valid, deny_count, d_data); end
    step;
    #3 reset_n = 1'b1;
    d_ready = 1'b1;
    step;
    n_cmp++; if (a_ready !== 1'b1 || d_valid !== 1'b0)
      begin n_bad++; $display("FAIL mid_release: got rdy=%b vld=%b want 1 0", a_ready, d_valid); end
    drive_a(3'd4, 2'd2, 4'd3, BASE + 32'h8, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
    step; a_valid = 1'b0;
    n_cmp++; if (d_source !== 4'd3 || d_data !== 32'd0 || d_denied !== 1'b0)
      begin n_bad++; $display("FAIL mid_regs: got src=%0d data=%h den=%b want 3 0 0", d_source, d_data, d_denied); end
    step;
  endtask

  initial begin
    test_reset;
    test_put_get;
    test_partial;
    test_deny;
    test_back_to_back;
    test_boundary;
    test_saturate;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/insight_tl_prot_responder.md
Name: insight_tl_prot_responder

Overview:
- TileLink-UL responder (manager side) for the A-channel AMBA-prot user field that Insight initiators attach to data requests.
- Accepts A-channel requests and enforces a prot-based access policy on a small local register window.
- Returns D-channel AccessAck/AccessAckData, with denied/corrupt set per policy, through a 2-entry response queue.
- Sits at the end of the Insight data TL path as the terminal slave for trace/debug control registers.

Parameters:
- ADDR_W, 32, A-channel address width
- SOURCE_W, 4, source ID width
- BASE_ADDR, 32'h0000_0000, byte address of register 0
- NREGS, 8, number of 32-bit registers (power of 2, ≥2)
- PRIV_IDX, 4, register index at or above which prot_privileged=1 is required

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- a_valid  in  1  A request valid
- a_ready  out  1  A request ready
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get; others unsupported
- a_size  in  2  log2 bytes
- a_source  in  SOURCE_W  request ID
- a_address  in  ADDR_W  byte address
- a_mask  in  4  byte lanes
- a_data  in  32  write data
- a_prot_privileged  in  1  amba_prot privileged bit
- a_prot_secure  in  1  amba_prot secure bit
- a_prot_fetch  in  1  amba_prot instruction-fetch bit
- d_valid  out  1  D response valid
- d_ready  in  1  D response ready
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_size  out  2  echo of a_size
- d_source  out  SOURCE_W  echo of a_source
- d_denied  out  1  access refused
- d_corrupt  out  1  data invalid
- d_data  out  32  read data
- deny_count  out  16  saturating count of denied requests

Behaviour:
- Reset (reset_n low, async): all registers 0; queue empty; d_valid=0, a_ready=1 after deassert; deny_count=0; d_* payload outputs 0.
- A handshake: a fire = a_valid & a_ready. a_ready = !queue_full. No combinational path d_ready→a_ready; when full, a simultaneous D dequeue does not enable same-cycle enqueue.
- Decode on fire: offset = a_address - BASE_ADDR; idx = offset[log2(NREGS)+1:2]; low 2 address bits ignored.
- Deny when any of: offset ≥ 4*NREGS; a_size > 2; opcode not in {0,1,4}; a_prot_fetch=1; idx ≥ PRIV_IDX and a_prot_privileged=0; a_prot_secure=0 and a_opcode is a Put.
- Granted Put: on fire, write byte lanes where a_mask[i]=1 (PutFullData also uses a_mask). Visible to a Get accepted the next cycle. Response AccessAck, denied=0, corrupt=0, data=0.
- Granted Get: read data captured at fire, not at dequeue. Response AccessAckData, data=reg[idx], denied=0, corrupt=0.
- Denied: no register write. Get → AccessAckData, denied=1, corrupt=1, data=0. Put or unsupported opcode → AccessAck, denied=1, corrupt=0.
- deny_count: +1 per denied fire; saturates at 16'hFFFF.
- Queue: 2-entry FIFO of {opcode, size, source, denied, corrupt, data}; responses leave in order.
- Latency: D response is registered. d_valid rises the cycle after fire when the queue was empty; throughput is 1 response/cycle at steady state.
- D payload is stable while d_valid=1 and d_ready=0. Pop on d_valid & d_ready.
- Simultaneous push and pop with 1 entry: count stays 1 and order is preserved.
- Async reset mid-transaction drops all queued responses; no D response is issued for them.

Test Plan:
- Put addr BASE+0x8, data 32'hA5A5_1234, mask 4'hF, privileged=1, secure=1 → AccessAck denied=0 one cycle later; then Get BASE+0x8 → AccessAckData data=32'hA5A5_1234.
- PutPartialData BASE+0x8, data 32'hFFFF_FFFF, mask 4'b0010 over the prior value → subsequent Get returns 32'hA5A5_FF34.
- Get BASE+0x10 (idx 4) with privileged=0 → AccessAckData denied=1, corrupt=1, data=0; deny_count=1. Then Get with fetch=1 → denied; deny_count=2.
- Hold d_ready=0 and issue 3 back-to-back Gets (sources 1,2,3) → a_ready drops after 2 fires. Raise d_ready → responses arrive with sources 1,2, then 3 is accepted and returned; payload stable while stalled.
- Get at BASE+4*NREGS, opcode 2, and a_size=3 → each denied; no register changes; deny_count forced to 16'hFFFF stays saturated.
- Assert reset_n low with 2 queued responses → d_valid=0 immediately, registers 0, a_ready=1 after release.
